// File: rtl/iobuf_bank_turnaround.sv
// Bank of bidirectional pad buffers sharing one tristate control.
// Drive is taken only after a fixed number of dead cycles; release is immediate.
module iobuf_bank_turnaround #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 1,
   parameter int IREG        = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] I,
   input  logic             T,
   inout  wire  [WIDTH-1:0] IO,
   output logic [WIDTH-1:0] O,
   output logic             DRV,
   output logic             TURN
);

   typedef enum logic [1:0] {
      ST_HIZ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   localparam logic [3:0] TURN_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic [3:0]       cnt_nxt;
   logic [WIDTH-1:0] dout;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_HIZ;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_HIZ: begin
            if (!T) begin
               if (TURN_CYCLES == 0) begin
                  state_nxt = ST_DRIVE;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = TURN_LOAD;
               end
            end
         end
         ST_WAIT: begin
            // An abort goes back to HIZ so the next request pays the full dead time.
            if (T) begin
               state_nxt = ST_HIZ;
            end else if (cnt == 4'd0) begin
               state_nxt = ST_DRIVE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ST_DRIVE: begin
            if (T) begin
               state_nxt = ST_HIZ;
            end
         end
         default: begin
            state_nxt = ST_HIZ;
         end
      endcase
   end

   // T gates the enable directly so the bus is freed before the next edge.
   always_comb begin
      DRV  = (state == ST_DRIVE) && !T;
      TURN = (state == ST_WAIT);
   end

   generate
      if (IREG != 0) begin : g_dout_reg
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               dout <= '0;
            end else begin
               dout <= I;
            end
         end
      end else begin : g_dout_comb
         assign dout = I;
      end
   endgenerate

   assign IO = DRV ? dout : {WIDTH{1'bz}};

   // Readback includes our own driven data.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         O <= '0;
      end else begin
         O <= IO;
      end
   end

endmodule

// File: tb/tb_iobuf_bank_turnaround.sv
// Bench for iobuf_bank_turnaround: four differently configured banks checked
// against a run-length model of the turnaround rule every cycle.
module tb_iobuf_bank_turnaround;

   localparam int N = 4;
   localparam int TC_P   [N] = '{3, 0, 2, 4};
   localparam int IREG_P [N] = '{1, 0, 1, 1};
   localparam int W_P    [N] = '{8, 8, 32, 8};

   logic        clk;
   logic        rst_n;
   logic        t       [N];
   logic [31:0] din     [N];
   logic        ext_en  [N];
   logic [31:0] ext_val [N];

   wire [7:0]  io0, io1, io3;
   wire [31:0] io2;
   wire [7:0]  o0, o1, o3;
   wire [31:0] o2;
   wire [3:0]  drv_w;
   wire [3:0]  turn_w;

   logic [31:0] io_v [N];
   logic [31:0] o_v  [N];

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   // A bank drives once the last TC+1 sampled edges since reset all saw T=0.
   int          run      [N];
   logic [31:0] dout_m   [N];
   logic [31:0] o_m      [N];
   bit          o_known  [N];

   assign io0 = ext_en[0] ? ext_val[0][7:0] : 8'bz;
   assign io1 = ext_en[1] ? ext_val[1][7:0] : 8'bz;
   assign io2 = ext_en[2] ? ext_val[2]      : 32'bz;
   assign io3 = ext_en[3] ? ext_val[3][7:0] : 8'bz;

   iobuf_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(3), .IREG(1)) u0 (
      .CLK(clk), .RST_N(rst_n), .I(din[0][7:0]), .T(t[0]), .IO(io0),
      .O(o0), .DRV(drv_w[0]), .TURN(turn_w[0]));
   iobuf_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(0), .IREG(0)) u1 (
      .CLK(clk), .RST_N(rst_n), .I(din[1][7:0]), .T(t[1]), .IO(io1),
      .O(o1), .DRV(drv_w[1]), .TURN(turn_w[1]));
   iobuf_bank_turnaround #(.WIDTH(32), .TURN_CYCLES(2), .IREG(1)) u2 (
      .CLK(clk), .RST_N(rst_n), .I(din[2]), .T(t[2]), .IO(io2),
      .O(o2), .DRV(drv_w[2]), .TURN(turn_w[2]));
   iobuf_bank_turnaround #(.WIDTH(8), .TURN_CYCLES(4), .IREG(1)) u3 (
      .CLK(clk), .RST_N(rst_n), .I(din[3][7:0]), .T(t[3]), .IO(io3),
      .O(o3), .DRV(drv_w[3]), .TURN(turn_w[3]));

   always_comb begin
      io_v[0] = {24'd0, io0};
      io_v[1] = {24'd0, io1};
      io_v[2] = io2;
      io_v[3] = {24'd0, io3};
      o_v[0]  = {24'd0, o0};
      o_v[1]  = {24'd0, o1};
      o_v[2]  = o2;
      o_v[3]  = {24'd0, o3};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wmask(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic expDrv(input int i);
      return (run[i] >= TC_P[i] + 1) && !t[i];
   endfunction

   function automatic logic expTurn(input int i);
      return (run[i] >= 1) && (run[i] <= TC_P[i]);
   endfunction

   // Value on the pad right now, and whether anybody is driving it.
   function automatic void modelBus(input int i, output logic [31:0] b, output bit k);
      if (expDrv(i)) begin
         b = ((IREG_P[i] != 0) ? dout_m[i] : din[i]) & wmask(W_P[i]);
         k = 1'b1;
      end else if (ext_en[i]) begin
         b = ext_val[i] & wmask(W_P[i]);
         k = 1'b1;
      end else begin
         b = 32'd0;
         k = 1'b0;
      end
   endfunction

   initial begin
      for (int i = 0; i < N; i++) begin
         run[i]     = 0;
         dout_m[i]  = 32'd0;
         o_m[i]     = 32'd0;
         o_known[i] = 1'b1;
      end
   end

   always @(posedge clk or negedge rst_n) begin : model_upd
      logic [31:0] b;
      bit          k;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            run[i]     = 0;
            dout_m[i]  = 32'd0;
            o_m[i]     = 32'd0;
            o_known[i] = 1'b1;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            modelBus(i, b, k);
            o_m[i]     = b;
            o_known[i] = k;
            if (t[i]) run[i] = 0;
            else if (run[i] < 1000) run[i] = run[i] + 1;
            dout_m[i] = din[i] & wmask(W_P[i]);
         end
      end
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] b;
      bit          k;
      logic [31:0] m;
      for (int i = 0; i < N; i++) begin
         m = wmask(W_P[i]);
         modelBus(i, b, k);
         checkVal($sformatf("%s drv%0d", tag, i), {31'd0, drv_w[i]}, {31'd0, expDrv(i)});
         checkVal($sformatf("%s turn%0d", tag, i), {31'd0, turn_w[i]}, {31'd0, expTurn(i)});
         if (k) checkVal($sformatf("%s io%0d", tag, i), io_v[i] & m, b);
         if (o_known[i]) checkVal($sformatf("%s o%0d", tag, i), o_v[i] & m, o_m[i] & m);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) checkOutput("cyc");
   end

   task automatic applyStimulus(input int i, input logic tv, input logic [31:0] dv);
      t[i]   = tv;
      din[i] = dv;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         t[i]       = 1'b1;
         din[i]     = 32'd0;
         ext_en[i]  = 1'b0;
         ext_val[i] = 32'd0;
      end
      #1 rst_n = 1'b0;
      tick(1);
      checkVal("reset drv", {28'd0, drv_w}, 32'd0);
      checkVal("reset turn", {28'd0, turn_w}, 32'd0);
      checkVal("reset o0", o_v[0], 32'd0);
      checkVal("reset o2", o_v[2], 32'd0);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      tick(2);

      // Turnaround on bank 0 (3 dead cycles) and zero-turnaround comb path on bank 1
      applyStimulus(0, 1'b0, 32'h3C);
      applyStimulus(1, 1'b0, 32'h5A);
      tick(1);
      checkVal("e0 turn0", {31'd0, turn_w[0]}, 32'd1);
      checkVal("e0 drv1", {31'd0, drv_w[1]}, 32'd1);
      checkVal("e0 io1", io_v[1], 32'h5A);
      din[1] = 32'h11;
      #1;
      checkVal("comb io1", io_v[1], 32'h11);
      checkOutput("mid");
      tick(3);
      checkVal("e3 drv0", {31'd0, drv_w[0]}, 32'd1);
      checkVal("e3 io0", io_v[0], 32'h3C);
      tick(1);
      checkVal("e4 o0", o_v[0], 32'h3C);

      // Combinational release with an external driver taking over
      t[0] = 1'b1; ext_val[0] = 32'hF0; ext_en[0] = 1'b1;
      t[1] = 1'b1; ext_val[1] = 32'h33; ext_en[1] = 1'b1;
      #1;
      checkVal("rel drv0", {31'd0, drv_w[0]}, 32'd0);
      checkVal("rel drv1", {31'd0, drv_w[1]}, 32'd0);
      checkOutput("rel");
      tick(1);
      checkVal("rel o0", o_v[0], 32'hF0);
      checkVal("rel o1", o_v[1], 32'h33);
      ext_en[0] = 1'b0;
      t[0]      = 1'b0;
      tick(3);
      checkVal("reentry drv0", {31'd0, drv_w[0]}, 32'd0);
      checkVal("reentry turn0", {31'd0, turn_w[0]}, 32'd1);
      tick(1);
      checkVal("reentry drv0 on", {31'd0, drv_w[0]}, 32'd1);

      // Abort during WAIT on bank 3 (4 dead cycles)
      applyStimulus(3, 1'b0, 32'h77);
      tick(2);
      t[3] = 1'b1;
      tick(1);
      checkVal("abort turn3", {31'd0, turn_w[3]}, 32'd0);
      checkVal("abort drv3", {31'd0, drv_w[3]}, 32'd0);
      t[3] = 1'b0;
      tick(4);
      checkVal("retry turn3", {31'd0, turn_w[3]}, 32'd1);
      checkVal("retry drv3", {31'd0, drv_w[3]}, 32'd0);
      tick(1);
      checkVal("retry drv3 on", {31'd0, drv_w[3]}, 32'd1);
      checkVal("retry io3", io_v[3], 32'h77);

      // 32-bit streaming on bank 2
      t[2] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         din[2] = 32'(k);
         tick(1);
      end
      din[2] = 32'hAAAA_AAAA; tick(1);
      din[2] = 32'h5555_5555; tick(1);
      din[2] = 32'h0000_0000; tick(1);
      din[2] = 32'hFFFF_FFFF; tick(1);
      checkVal("stream io2", io_v[2], 32'hFFFF_FFFF);
      tick(1);
      checkVal("stream o2", o_v[2], 32'hFFFF_FFFF);

      // Asynchronous reset in the middle of driving
      din[2] = 32'hA5;
      tick(1);
      checkVal("pre-rst io2", io_v[2], 32'hA5);
      rst_n = 1'b0;
      #1;
      checkVal("rst drv2", {31'd0, drv_w[2]}, 32'd0);
      checkVal("rst o2", o_v[2], 32'd0);
      checkVal("rst drv0", {31'd0, drv_w[0]}, 32'd0);
      checkOutput("rst");
      #1 rst_n = 1'b1;
      tick(2);
      checkVal("post-rst drv2", {31'd0, drv_w[2]}, 32'd0);
      checkVal("post-rst turn2", {31'd0, turn_w[2]}, 32'd1);
      tick(1);
      checkVal("post-rst drv2 on", {31'd0, drv_w[2]}, 32'd1);
      checkVal("post-rst io2", io_v[2], 32'hA5);

      tick(2);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
